// File: rtl/ocb_pkg.sv
// Shared types and constants for the OCB result checker.
package ocb_pkg;

  localparam int OCB_ADDR_W   = 9;
  localparam int OCB_DATA_W   = 32;
  localparam int OCB_MAXBIT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  // Number of bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/ocb_msb_index.sv
// Combinational priority encoder: index of the highest set bit of vec_i.
// valid_o is low (and idx_o zero) when vec_i has no bit set.
module ocb_msb_index #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic [DATA_W-1:0] vec_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ocb_result_checker.sv
// Compares DUT and golden result words over one RX address sweep and keeps
// mismatch statistics (count, first failure, highest differing bit).
module ocb_result_checker
  import ocb_pkg::*;
#(
  parameter int DATA_W = OCB_DATA_W,
  parameter int ADDR_W = OCB_ADDR_W,
  parameter int CNT_W  = 10
) (
  input  logic                    CTRL_CLK,
  input  logic                    CTRL_RESET_N,
  input  logic                    CHK_CLEAR,
  input  logic [ADDR_W-1:0]       CTRL_RX_MEMADDR,
  input  logic                    CTRL_RX_WREN,
  input  logic [DATA_W-1:0]       DUT_RESULT,
  input  logic [DATA_W-1:0]       GOLD_RESULT,
  output logic [CNT_W-1:0]        CHK_ERR_COUNT,
  output logic [ADDR_W-1:0]       CHK_FIRST_ADDR,
  output logic [DATA_W-1:0]       CHK_FIRST_DIFF,
  output logic [OCB_MAXBIT_W-1:0] CHK_MAX_BIT,
  output logic                    CHK_ANY_ERR,
  output logic                    CHK_DONE,
  output logic                    CHK_BUSY
);

  localparam int                MSB_W     = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;

  chk_state_t state_q, state_d;

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s1_dut_q, s1_gold_q;
  logic [DATA_W-1:0] s1_diff;
  logic [MSB_W-1:0]  s1_msb;
  logic              s1_mismatch;

  logic              s2_valid_q, s2_mismatch_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [DATA_W-1:0] s2_diff_q;
  logic [MSB_W-1:0]  s2_msb_q;
  logic [OCB_MAXBIT_W-1:0] s2_msb_ext;

  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]       first_addr_q, first_addr_d;
  logic [DATA_W-1:0]       first_diff_q, first_diff_d;
  logic [OCB_MAXBIT_W-1:0] max_bit_q, max_bit_d;
  logic                    any_err_q, any_err_d;

  logic accept, last_word;

  assign s1_diff = s1_dut_q ^ s1_gold_q;

  ocb_msb_index #(
    .DATA_W (DATA_W),
    .IDX_W  (MSB_W)
  ) u_msb_index (
    .vec_i   (s1_diff),
    .idx_o   (s1_msb),
    .valid_o (s1_mismatch)
  );

  // A clear empties the pipe so nothing from the previous sweep leaks in.
  always_ff @(posedge CTRL_CLK or negedge CTRL_RESET_N) begin
    if (!CTRL_RESET_N) begin
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= '0;
      s1_dut_q      <= '0;
      s1_gold_q     <= '0;
      s2_valid_q    <= 1'b0;
      s2_mismatch_q <= 1'b0;
      s2_addr_q     <= '0;
      s2_diff_q     <= '0;
      s2_msb_q      <= '0;
    end else begin
      s1_valid_q    <= CTRL_RX_WREN & ~CHK_CLEAR;
      s1_addr_q     <= CTRL_RX_MEMADDR;
      s1_dut_q      <= DUT_RESULT;
      s1_gold_q     <= GOLD_RESULT;
      s2_valid_q    <= s1_valid_q & ~CHK_CLEAR;
      s2_mismatch_q <= s1_mismatch;
      s2_addr_q     <= s1_addr_q;
      s2_diff_q     <= s1_diff;
      s2_msb_q      <= s1_msb;
    end
  end

  assign s2_msb_ext = OCB_MAXBIT_W'(s2_msb_q);
  assign accept     = s2_valid_q & ~CHK_CLEAR & ((state_q == ARMED) | (state_q == RUN));
  assign last_word  = accept & (s2_addr_q == LAST_ADDR);

  always_ff @(posedge CTRL_CLK or negedge CTRL_RESET_N) begin
    if (!CTRL_RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (CHK_CLEAR) begin
      state_d = ARMED;
    end else if (accept) begin
      state_d = last_word ? DONE : RUN;
    end
  end

  always_comb begin
    CHK_BUSY = (state_q == RUN);
    CHK_DONE = (state_q == DONE);
  end

  always_comb begin
    err_cnt_d    = err_cnt_q;
    first_addr_d = first_addr_q;
    first_diff_d = first_diff_q;
    max_bit_d    = max_bit_q;
    any_err_d    = any_err_q;
    if (CHK_CLEAR) begin
      err_cnt_d    = '0;
      first_addr_d = '0;
      first_diff_d = '0;
      max_bit_d    = '0;
      any_err_d    = 1'b0;
    end else if (accept && s2_mismatch_q) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end
      any_err_d = 1'b1;
      if (!any_err_q) begin
        first_addr_d = s2_addr_q;
        first_diff_d = s2_diff_q;
      end
      if (s2_msb_ext > max_bit_q) begin
        max_bit_d = s2_msb_ext;
      end
    end
  end

  always_ff @(posedge CTRL_CLK or negedge CTRL_RESET_N) begin
    if (!CTRL_RESET_N) begin
      err_cnt_q    <= '0;
      first_addr_q <= '0;
      first_diff_q <= '0;
      max_bit_q    <= '0;
      any_err_q    <= 1'b0;
    end else begin
      err_cnt_q    <= err_cnt_d;
      first_addr_q <= first_addr_d;
      first_diff_q <= first_diff_d;
      max_bit_q    <= max_bit_d;
      any_err_q    <= any_err_d;
    end
  end

  assign CHK_ERR_COUNT  = err_cnt_q;
  assign CHK_FIRST_ADDR = first_addr_q;
  assign CHK_FIRST_DIFF = first_diff_q;
  assign CHK_MAX_BIT    = max_bit_q;
  assign CHK_ANY_ERR    = any_err_q;

endmodule
